// File: rtl/intersection_pkg.sv
// Shared intersection definitions: phase codes, lamp-driver state encoding,
// lamp bundle types and the phase-to-lamp decode.
package intersection_pkg;

  typedef logic [2:0] phase_t;

  localparam phase_t N_GREEN  = 3'b000;
  localparam phase_t N_YELLOW = 3'b001;
  localparam phase_t RED_1    = 3'b010;
  localparam phase_t E_LEFT   = 3'b011;
  localparam phase_t E_GREEN  = 3'b100;
  localparam phase_t E_YELLOW = 3'b101;
  localparam phase_t RED_2    = 3'b110;
  localparam phase_t N_LEFT   = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  typedef struct packed {
    logic red;
    logic yel;
    logic grn;
    logic left;
  } lamp_t;

  typedef struct packed {
    lamp_t n;
    lamp_t e;
  } lamps_t;

  localparam lamps_t ALL_RED = lamps_t'(8'b1000_1000);

  // Start from both reds and clear/set only what each phase changes.
  function automatic lamps_t decode_phase(input phase_t code);
    lamps_t l;
    l = ALL_RED;
    case (code)
      N_GREEN:      begin l.n.red = 1'b0; l.n.grn = 1'b1; end
      N_YELLOW:     begin l.n.red = 1'b0; l.n.yel = 1'b1; end
      E_LEFT:       l.e.left = 1'b1;
      E_GREEN:      begin l.e.red = 1'b0; l.e.grn = 1'b1; end
      E_YELLOW:     begin l.e.red = 1'b0; l.e.yel = 1'b1; end
      N_LEFT:       l.n.left = 1'b1;
      default:      l = ALL_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/lamp_driver_phase_filter.sv
// Debounce filter for the incoming phase code: a code is reported valid once
// it has been sampled identically on STABLE_CYC consecutive edges.
module phase_filter
  import intersection_pkg::*;
#(
  parameter int STABLE_CYC = 3
) (
  input  logic   clk,
  input  logic   reset,
  input  phase_t phase_in,
  output logic   code_valid,
  output phase_t code_out,
  output phase_t stable_code
);

  localparam int CW = $clog2(STABLE_CYC + 1);

  phase_t        samp_q, samp_d;
  phase_t        stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    samp_d = phase_in;
    cnt_d  = CW'(1);
    if (phase_in == samp_q) begin
      cnt_d = (cnt_q == CW'(STABLE_CYC)) ? cnt_q : cnt_q + CW'(1);
    end
    // Validity includes the current sample so acceptance lands on the last stable edge.
    code_valid = (cnt_d == CW'(STABLE_CYC));
    code_out   = phase_in;
    stable_d   = code_valid ? phase_in : stable_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_q   <= N_GREEN;
      cnt_q    <= '0;
      stable_q <= N_GREEN;
    end else begin
      samp_q   <= samp_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_code = stable_q;

endmodule

// File: rtl/lamp_driver.sv
// Lamp driver: sequence-checks filtered phase codes, decodes them to North/East
// lamps, and flashes both reds while latched in FAULT until cleared at N_GREEN.
module lamp_driver
  import intersection_pkg::*;
#(
  parameter int STABLE_CYC = 3,
  parameter int FLASH_DIV  = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] phase_in,
  input  logic       fault_clr,
  output logic       n_red,
  output logic       n_yel,
  output logic       n_grn,
  output logic       n_left,
  output logic       e_red,
  output logic       e_yel,
  output logic       e_grn,
  output logic       e_left,
  output logic       fault
);

  localparam int FCW = $clog2(FLASH_DIV + 1);

  logic       code_valid;
  phase_t     code_out;
  phase_t     stable_code;

  logic [1:0]     state_q, state_d;
  phase_t         cur_q, cur_d;
  logic [FCW-1:0] flash_cnt_q, flash_cnt_d;
  logic           flash_on_q, flash_on_d;
  lamps_t         lamps_q, lamps_d;
  logic           fault_q, fault_d;

  phase_filter #(.STABLE_CYC(STABLE_CYC)) u_filter (
    .clk        (clk),
    .reset      (reset),
    .phase_in   (phase_in),
    .code_valid (code_valid),
    .code_out   (code_out),
    .stable_code(stable_code)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    case (state_q)
      ST_IDLE: begin
        if (code_valid) begin
          cur_d   = code_out;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (code_valid && code_out != cur_q) begin
          if (code_out == cur_q + 3'd1) cur_d   = code_out;
          else                          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (fault_clr && stable_code == N_GREEN) begin
          cur_d   = N_GREEN;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outside FAULT the counter parks at 0 with the flash phase "on", so entry starts lit.
  always_comb begin
    flash_cnt_d = '0;
    flash_on_d  = 1'b1;
    if (state_q == ST_FAULT) begin
      if (flash_cnt_q == FCW'(FLASH_DIV - 1)) begin
        flash_on_d = ~flash_on_q;
      end else begin
        flash_cnt_d = flash_cnt_q + FCW'(1);
        flash_on_d  = flash_on_q;
      end
    end
  end

  always_comb begin
    lamps_d = ALL_RED;
    fault_d = (state_q == ST_FAULT);
    case (state_q)
      ST_RUN:   lamps_d = decode_phase(cur_q);
      ST_FAULT: begin
        lamps_d       = '0;
        lamps_d.n.red = flash_on_q;
        lamps_d.e.red = flash_on_q;
      end
      default:  lamps_d = ALL_RED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_q       <= N_GREEN;
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b1;
      lamps_q     <= ALL_RED;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      flash_cnt_q <= flash_cnt_d;
      flash_on_q  <= flash_on_d;
      lamps_q     <= lamps_d;
      fault_q     <= fault_d;
    end
  end

  assign n_red  = lamps_q.n.red;
  assign n_yel  = lamps_q.n.yel;
  assign n_grn  = lamps_q.n.grn;
  assign n_left = lamps_q.n.left;
  assign e_red  = lamps_q.e.red;
  assign e_yel  = lamps_q.e.yel;
  assign e_grn  = lamps_q.e.grn;
  assign e_left = lamps_q.e.left;
  assign fault  = fault_q;

endmodule

// File: tb/tb_lamp_driver.sv
// Bench for lamp_driver: directed scenarios plus randomized phase traffic,
// all outputs compared every edge against a history-based reference model.
module tb_lamp_driver;

  localparam int S = 3;
  localparam int D = 4;
  localparam logic [8:0] REDS = 9'b0_1000_1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fault_clr = 1'b0;
  logic [2:0] phase_in = 3'b000;
  logic n_red, n_yel, n_grn, n_left, e_red, e_yel, e_grn, e_left, fault;

  lamp_driver #(.STABLE_CYC(S), .FLASH_DIV(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .phase_in (phase_in),
    .fault_clr(fault_clr),
    .n_red    (n_red),
    .n_yel    (n_yel),
    .n_grn    (n_grn),
    .n_left   (n_left),
    .e_red    (e_red),
    .e_yel    (e_yel),
    .e_grn    (e_grn),
    .e_left   (e_left),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  logic [8:0] dut_out;
  assign dut_out = {fault, n_red, n_yel, n_grn, n_left, e_red, e_yel, e_grn, e_left};

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 run, 2 fault; hist holds recent samples.
  int m_mode = 0;
  int m_cur  = 0;
  int m_st   = 0;
  int m_age  = 0;
  int hist[$];

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  // Bit order: n_red n_yel n_grn n_left e_red e_yel e_grn e_left.
  function automatic logic [7:0] lamp_table(input int code);
    case (code)
      0:       return 8'b0010_1000;
      1:       return 8'b0100_1000;
      3:       return 8'b1000_1001;
      4:       return 8'b1000_0010;
      5:       return 8'b1000_0100;
      7:       return 8'b1001_1000;
      default: return 8'b1000_1000;
    endcase
  endfunction

  function automatic logic [8:0] model_out();
    logic red;
    if (m_mode == 1) return {1'b0, lamp_table(m_cur)};
    if (m_mode == 2) begin
      red = ((m_age / D) % 2) == 0;
      return {1'b1, red, 3'b000, red, 3'b000};
    end
    return REDS;
  endfunction

  task automatic model_update();
    bit stable_now;
    if (reset) begin
      m_mode = 0; m_cur = 0; m_st = 0; m_age = 0;
      hist.delete();
    end else begin
      hist.push_back(int'(phase_in));
      if (hist.size() > S) void'(hist.pop_front());
      stable_now = (hist.size() == S);
      foreach (hist[i]) if (hist[i] != int'(phase_in)) stable_now = 0;
      case (m_mode)
        0: if (stable_now) begin m_cur = int'(phase_in); m_mode = 1; end
        1: if (stable_now && int'(phase_in) != m_cur) begin
             if (int'(phase_in) == (m_cur + 1) % 8) m_cur = int'(phase_in);
             else begin m_mode = 2; m_age = 0; end
           end
        default: begin
          m_age++;
          if (fault_clr && m_st == 0) begin m_mode = 1; m_cur = 0; end
        end
      endcase
      if (stable_now) m_st = int'(phase_in);
    end
  endtask

  task automatic tick();
    logic [8:0] exp;
    exp = reset ? REDS : model_out();
    @(posedge clk);
    model_update();
    #1;
    check("outputs", dut_out, exp);
  endtask

  task automatic hold(input logic [2:0] code, input int n);
    phase_in = code;
    repeat (n) tick();
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;

    // Power-up: reds until the first stable code, then N_GREEN.
    hold(3'd0, 3);
    check("idle_reds", dut_out, REDS);
    tick();
    check("first_run", dut_out, 9'b0_0010_1000);

    // Full legal cycle including the 111 -> 000 wrap.
    for (int c = 1; c <= 8; c++) hold(3'(c % 8), 10);

    // Glitch while at N_YELLOW.
    hold(3'd1, 10);
    hold(3'd5, 2);
    hold(3'd1, 6);
    check("glitch", dut_out, 9'b0_0100_1000);

    // Illegal jump 001 -> 100, then flashing.
    hold(3'd4, 3);
    tick();
    check("fault_entry", dut_out, 9'b1_1000_1000);
    hold(3'd4, 16);

    // Clear with a non-zero stable code is ignored.
    hold(3'd3, 5);
    pulse_clr();
    hold(3'd3, 3);
    check("clr_ignored", {fault, 8'h00}, 9'h100);

    // Clear with stable 000 returns to RUN at N_GREEN.
    hold(3'd0, 4);
    pulse_clr();
    tick();
    check("clr_exit", dut_out, 9'b0_0010_1000);

    // Fault again (000 -> 010), reset during flash-off, then first code 101.
    hold(3'd2, 3);
    hold(3'd2, 6);
    check("flash_off", dut_out, 9'b1_0000_0000);
    reset = 1'b1;
    tick();
    check("reset_in_fault", dut_out, REDS);
    reset = 1'b0;
    hold(3'd5, 3);
    tick();
    check("first_code_101", dut_out, 9'b0_1000_0100);

    // Randomized traffic: mostly legal advances, some glitches, jumps, clears, resets.
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else if (m_mode == 2 && r < 40) begin
        hold(3'd0, $urandom_range(2, 5));
        pulse_clr();
      end else if (r < 12) begin
        hold(3'($urandom_range(0, 7)), $urandom_range(1, 6));
      end else if (r < 20) begin
        hold(3'($urandom_range(0, 7)), $urandom_range(1, 2));
      end else if (r < 25) begin
        pulse_clr();
      end else begin
        hold(3'((m_cur + 1) % 8), $urandom_range(3, 8));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lamp_driver.md
# lamp_driver

Downstream consumer of the intersection controller's 3-bit phase code. It filters the code, checks that phases advance only in legal sequence order, and decodes each accepted phase into individual lamp drives for the North and East approaches. On an illegal phase jump it latches a fault and flashes all reds until explicitly cleared. It sits between the traffic FSM's `ledOut` and the board lamp/LED pins.

## Interface
Parameters:
- `STABLE_CYC`, 3: consecutive identical samples required before a new phase code is accepted (min 1).
- `FLASH_DIV`, 25000000: clock cycles per half-period of the fault red flash (0.5 s at 50 MHz); min 1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock (CLOCK_50 domain).
- `reset` in 1: synchronous, active-high reset.
- `phase_in` in 3: phase code from the traffic controller.
- `fault_clr` in 1: single-cycle pulse requesting exit from FAULT.
- `n_red`, `n_yel`, `n_grn`, `n_left` out 1 each: North lamps, registered.
- `e_red`, `e_yel`, `e_grn`, `e_left` out 1 each: East lamps, registered.
- `fault` out 1: high while in FAULT, registered.

## Operation
- Phase codes: 000 N_GREEN, 001 N_YELLOW, 010 RED_1, 011 E_LEFT, 100 E_GREEN, 101 E_YELLOW, 110 RED_2, 111 N_LEFT.
- Lamp decode in RUN:
  - 000 is n_grn+e_red; 001 is n_yel+e_red; 010 and 110 are n_red+e_red.
  - 011 is e_left+n_red+e_red; 100 is e_grn+n_red; 101 is e_yel+n_red; 111 is n_left+n_red+e_red.
  - All unlisted lamps are 0.
- Filter: `phase_in` is sampled every edge. A code is accepted only after it has been sampled identically on STABLE_CYC consecutive edges and it differs from `cur_code`. Shorter glitches are ignored.
- Legality: an accepted code is legal iff it equals `cur_code`+1 mod 8 (111 to 000 wraps).
- States:
  - IDLE (after reset): all reds steady on. The first accepted code of any value loads `cur_code`, moves to RUN, and performs no legality check.
  - RUN: a legal accepted code updates `cur_code` and the lamps. An illegal accepted code leaves `cur_code` unchanged and moves to FAULT.
  - FAULT: yellow/green/left lamps off. n_red and e_red flash together, on for FLASH_DIV cycles then off for FLASH_DIV cycles, starting on. `fault`=1.
  - FAULT exit: `fault_clr`=1 while the filtered stable code is 000 loads `cur_code`=000 and moves to RUN. `fault_clr` with any other stable code is ignored (no effect, no latching).
- The flash counter resets to 0 on FAULT entry and holds at 0 outside FAULT.

## Timing
- Reset: state IDLE, `cur_code`=000, flash counter 0, filter count 0. Outputs after the reset edge: n_red=e_red=1, all other lamps 0, fault=0.
- Reset mid-operation, including in FAULT, returns to IDLE on the same edge.
- Latency: a new code is first sampled on edge k and held through edge k+STABLE_CYC-1. `cur_code`/state update on edge k+STABLE_CYC-1. Lamps and `fault` update on edge k+STABLE_CYC.
- Glitch: a code present for fewer than STABLE_CYC edges produces no output change and no fault.
- An illegal code enters FAULT with the same latency. Lamps show flash-on (reds on, others off) on the next edge.
- Simultaneous `fault_clr` and an illegal acceptance in RUN: FAULT wins.
- `fault_clr` in RUN or IDLE: no effect.
- The flash toggles exactly every FLASH_DIV edges while in FAULT. The counter width is ceil(log2(FLASH_DIV+1)). The filter counter saturates at STABLE_CYC.

## Structure
- Shared package `intersection_pkg`: the 3-bit phase code localparams (N_GREEN through N_LEFT) and the lamp-state encoding (IDLE/RUN/FAULT). The traffic controller uses the same phase constants.
- Sub-module `phase_filter`:
  - Contents: sample register, stability counter, and the `code_valid` pulse with `code_out` on acceptance.
  - Output: also exposes `stable_code` for the fault-clear check.
- The top holds the state machine, the legality check, the decode, and the flash counter.

## Test plan
- Reset then hold 000 for 3 edges -> IDLE to RUN on edge 3, then n_grn=1, e_red=1, fault=0. Before that, only reds are on.
- Full legal cycle 000..111..000, each held 10 cycles (STABLE_CYC=3) -> every lamp decode matches the list, each change occurs 3 edges after the code change, and fault stays 0 through the wrap.
- In RUN at 001, a 2-cycle glitch to 101, then back to 001 -> no lamp change, fault=0.
- In RUN at 001, jump to 100 held steady -> fault=1 after 3 edges. With FLASH_DIV=4, reds follow 4 on / 4 off repeatedly and other lamps are 0.
- In FAULT:
  - `fault_clr` pulse with stable 011 -> stays in FAULT.
  - Then drive 000 stable and pulse `fault_clr` -> next edge n_grn=1, e_red=1, fault=0.
- Assert reset during FAULT mid-flash-off -> next edge reds on steady, fault=0, IDLE. A subsequent first code of 101 is accepted without fault.
